// File: rtl/inv_mix_column_seq.sv
// inv_mix_column_seq
//   Sequential AES (Inv)MixColumns engine that produces one output byte per
//   clock, so a full 128-bit state takes 16 cycles after acceptance.
//   INVERSE=1 selects coefficients {0E,0B,0D,09}; INVERSE=0 selects {02,03,01,01}.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream offers in_state
//   in_ready   block is idle and will latch in_state on this edge
//   in_state   128-bit state, [127:96] = column 0, MSB byte of a column = row 0
//   out_valid  out_state holds a completed result
//   out_ready  downstream takes the result
//   out_state  transformed state, same layout as in_state
//   busy       operation in progress or result waiting
module inv_mix_column_seq #(
  parameter int unsigned INVERSE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t       state;
  logic [3:0]   idx;
  logic [127:0] src;
  logic [127:0] out_q;
  logic [7:0]   new_byte;

  // GF(2^8) multiply, reduction polynomial 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = '0;
    aa = a;
    bb = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      bb = bb >> 1;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] coef(input logic [1:0] k);
    logic [7:0] v;
    if (INVERSE != 0) begin
      case (k)
        2'd0:    v = 8'h0e;
        2'd1:    v = 8'h0b;
        2'd2:    v = 8'h0d;
        default: v = 8'h09;
      endcase
    end else begin
      case (k)
        2'd0:    v = 8'h02;
        2'd1:    v = 8'h03;
        default: v = 8'h01;
      endcase
    end
    return v;
  endfunction

  // Byte number n (n = 4*column + row) lives at bit offset 8*(15-n) = {~n,3'b000}.
  function automatic logic [7:0] mix_byte(input logic [127:0] s, input logic [3:0] i);
    logic [7:0] acc;
    logic [1:0] r;
    logic [1:0] jj;
    logic [3:0] b;
    logic [6:0] base;
    acc = '0;
    r   = i[1:0];
    for (int unsigned j = 0; j < 4; j++) begin
      jj   = 2'(j);
      b    = {i[3:2], jj};
      base = {~b, 3'b000};
      acc  = acc ^ gmul(coef(jj - r), s[base +: 8]);
    end
    return acc;
  endfunction

  always_comb begin
    new_byte = mix_byte(src, idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      src   <= '0;
      out_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            src   <= in_state;
            idx   <= '0;
            state <= COMPUTE;
          end
        end
        COMPUTE: begin
          out_q[{~idx, 3'b000} +: 8] <= new_byte;
          idx <= idx + 4'd1;
          if (idx == 4'd15) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_state = out_q;

endmodule

// File: tb/tb_inv_mix_column_seq.sv
module tb_inv_mix_column_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] in_state = '0;
  logic         out_ready = 1'b0;

  logic         in_ready_i, out_valid_i, busy_i;
  logic [127:0] out_state_i;
  logic         in_ready_f, out_valid_f, busy_f;
  logic [127:0] out_state_f;

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] VEC_A = 128'h8e4da1bc_9fdc589d_c6c6c6c6_01010101;
  localparam logic [127:0] VEC_B = 128'hdb135345_f20a225c_c6c6c6c6_01010101;

  inv_mix_column_seq #(.INVERSE(1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_i),
    .in_state(in_state), .out_valid(out_valid_i), .out_ready(out_ready),
    .out_state(out_state_i), .busy(busy_i)
  );

  inv_mix_column_seq #(.INVERSE(0)) dut_fwd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_f),
    .in_state(in_state), .out_valid(out_valid_f), .out_ready(out_ready),
    .out_state(out_state_f), .busy(busy_f)
  );

  always #5 clk = ~clk;

  // Reference: carry-less product followed by polynomial long division.
  function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // Reference: full matrix-times-column product for every column.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
    logic [7:0] m_inv [4][4];
    logic [7:0] m_fwd [4][4];
    logic [7:0] col [4];
    logic [7:0] acc;
    logic [127:0] res;
    m_inv = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
              '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
    m_fwd = '{'{8'h02, 8'h03, 8'h01, 8'h01}, '{8'h01, 8'h02, 8'h03, 8'h01},
              '{8'h01, 8'h01, 8'h02, 8'h03}, '{8'h03, 8'h01, 8'h01, 8'h02}};
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) col[j] = s[127 - 8*(4*c + j) -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++)
          acc = acc ^ ref_gmul(inv ? m_inv[r][j] : m_fwd[r][j], col[j]);
        res[127 - 8*(4*c + r) -: 8] = acc;
      end
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand_state();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts and ends at a negedge with the block idle.
  task automatic run(input logic [127:0] st, input bit corrupt, input int hold);
    logic [127:0] exp_i, exp_f;
    int edges;
    exp_i = ref_mix(st, 1'b1);
    exp_f = ref_mix(st, 1'b0);
    check("idle_in_ready", {127'd0, in_ready_i}, 128'd1);
    in_valid = 1'b1;
    in_state = st;
    step();                                   // E0 accepts
    in_valid = 1'b0;
    in_state = rand_state();
    check("accept_busy", {126'd0, busy_i, in_ready_i}, 128'd2);
    edges = 0;
    while (!out_valid_i && edges < 40) begin
      step();
      edges++;
      if (corrupt && edges == 5) begin
        in_state = '1;
        in_valid = 1'b1;
      end
      if (edges == 6) in_valid = 1'b0;
    end
    check("latency", 128'(edges), 128'd16);
    check("done_flags", {125'd0, out_valid_f, in_ready_i, busy_i}, 128'd5);
    check("result_inv", out_state_i, exp_i);
    check("result_fwd", out_state_f, exp_f);
    for (int h = 0; h < hold; h++) begin
      step();
      check("hold_flags", {126'd0, out_valid_i, in_ready_i}, 128'd2);
      check("hold_data", out_state_i, exp_i);
      in_valid = (h == 3);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("release_flags", {125'd0, out_valid_i, in_ready_i, busy_i}, 128'd2);
    check("idle_keeps_result", out_state_i, exp_i);
  endtask

  initial begin
    logic [127:0] first, second;
    int edges;

    // Reset state
    #1;
    check("reset_out_state", out_state_i, '0);
    check("reset_flags", {125'd0, out_valid_i, in_ready_i, busy_i}, 128'd2);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Known vectors
    run(VEC_A, 1'b0, 0);
    check("fips_inverse", out_state_i, VEC_B);
    run(VEC_B, 1'b0, 0);
    check("fips_forward", out_state_f, VEC_A);

    // Backpressure with ignored in_valid pulse
    run(rand_state(), 1'b0, 10);

    // Input corruption mid-operation
    run(rand_state(), 1'b1, 0);

    // Random states
    for (int n = 0; n < 6; n++) run(rand_state(), 1'b0, n % 3);
    run('0, 1'b0, 0);
    run('1, 1'b0, 0);

    // Reset mid-operation
    in_valid = 1'b1;
    in_state = rand_state();
    step();
    in_valid = 1'b0;
    for (int e = 0; e < 8; e++) step();
    rst_n = 1'b0;
    #1;
    check("midreset_out_state", out_state_i, '0);
    check("midreset_flags", {125'd0, out_valid_i, in_ready_i, busy_i}, 128'd2);
    @(negedge clk);
    rst_n = 1'b1;
    run(VEC_A, 1'b0, 0);
    check("after_reset_fips", out_state_i, VEC_B);

    // Back-to-back, out_ready tied high (also during COMPUTE)
    first  = rand_state();
    second = rand_state();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_state  = first;
    step();                                   // E0
    in_state = second;
    edges = 0;
    while (!out_valid_i && edges < 40) begin
      step();
      edges++;
    end
    check("b2b_latency1", 128'(edges), 128'd16);
    check("b2b_result1", out_state_i, ref_mix(first, 1'b1));
    step();                                   // DONE -> IDLE
    check("b2b_idle_flags", {126'd0, out_valid_i, in_ready_i}, 128'd1);
    step();                                   // second accepted
    check("b2b_accept", {126'd0, busy_i, in_ready_i}, 128'd2);
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid_i && edges < 40) begin
      step();
      edges++;
    end
    check("b2b_latency2", 128'(edges), 128'd16);
    check("b2b_result2_inv", out_state_i, ref_mix(second, 1'b1));
    check("b2b_result2_fwd", out_state_f, ref_mix(second, 1'b0));
    step();
    out_ready = 1'b0;
    check("b2b_final_idle", {126'd0, out_valid_i, in_ready_i}, 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inv_mix_column_seq.md
INV_MIX_COLUMN_SEQ -- requirements
Module: inv_mix_column_seq

Interface
REQ-001 The block SHALL have parameter INVERSE, default 1, meaning 1 = inverse MixColumns coefficients {0E,0B,0D,09} and 0 = forward coefficients {02,03,01,01}.
REQ-002 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port in_valid  input  1  upstream presents a valid 128-bit state.
REQ-005 Port in_ready  output  1  block can accept a state this cycle.
REQ-006 Port in_state  input  128  input state; [127:96] = column 0 … [31:0] = column 3; within a column the MSB byte is row 0.
REQ-007 Port out_valid  output  1  out_state holds a completed result.
REQ-008 Port out_ready  input  1  downstream accepts the result.
REQ-009 Port out_state  output  128  transformed state, same byte layout as in_state.
REQ-010 Port busy  output  1  high in COMPUTE and DONE.

Function
REQ-011 The FSM SHALL have three states: IDLE, COMPUTE and DONE.
REQ-012 IDLE behaviour: in_ready=1, out_valid=0, busy=0; when in_valid=1 on an edge, the block latches in_state into an internal source register, clears the 4-bit index idx to 0 and goes to COMPUTE.
REQ-013 COMPUTE behaviour: in_ready=0; on each edge the block computes exactly one output byte for column c=idx[3:2] and row r=idx[1:0], writes it into the out_state byte (c,r), then increments idx.
REQ-014 Byte (c,r) SHALL equal the XOR over j=0..3 of gmul(K[(j−r) mod 4], src(c,j)), where K = {K0,K1,K2,K3} is the INVERSE-selected coefficient vector (row r = K rotated right by r).
REQ-015 gmul SHALL be a GF(2^8) multiply reduced by x^8+x^4+x^3+x+1 (0x11B); the 8-bit result has no carry-out.
REQ-016 Transition COMPUTE -> DONE SHALL occur on the edge that writes idx=15; idx wraps to 0 and out_valid rises on that same edge.
REQ-017 Latency: if the accepting edge is E0, COMPUTE writes occur on E1..E16 and out_valid=1 from E16; total of 16 cycles from acceptance to result.
REQ-018 DONE behaviour: out_valid=1 and in_ready=0; out_state SHALL remain stable until out_ready=1 is sampled on an edge, after which the FSM returns to IDLE with out_valid=0.
REQ-019 The block SHALL ignore in_valid and in_state outside IDLE; the latched source register is the only operand in use during COMPUTE.
REQ-020 in_ready and out_valid SHALL never both be 1; a new state is accepted no earlier than the cycle after the DONE->IDLE edge.
REQ-021 out_state SHALL keep its last result while in IDLE and SHALL be overwritten byte by byte only during COMPUTE.
REQ-022 If out_ready is 1 before DONE, it SHALL have no effect.

Reset
REQ-023 While rst_n=0, the block SHALL immediately set: FSM=IDLE, idx=0, source register=0, out_state=0, out_valid=0, busy=0 and in_ready=1.
REQ-024 Assertion of rst_n during COMPUTE or DONE SHALL abort the operation with no partial result kept; after release the block SHALL accept a new state on the first edge with in_valid=1.

Verification
REQ-025 Inverse FIPS-197 vector (INVERSE=1): in_state=8e4da1bc_9fdc589d_c6c6c6c6_01010101 -> out_state=db135345_f20a225c_c6c6c6c6_01010101, with out_valid rising exactly 16 edges after acceptance.
REQ-026 Forward vector (INVERSE=0): in_state=db135345_f20a225c_c6c6c6c6_01010101 -> out_state=8e4da1bc_9fdc589d_c6c6c6c6_01010101.
REQ-027 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_state is unchanged, in_ready=0 and a pulse on in_valid is ignored; then out_ready=1 -> IDLE on the next edge.
REQ-028 Input change mid-operation: change in_state to all-ones at E5 of COMPUTE -> the result still matches the originally latched state.
REQ-029 Reset mid-operation: drive rst_n=0 at E8 -> out_state=0, out_valid=0 and in_ready=1 immediately; after release, a fresh 8e4da1bc… input completes correctly in 16 cycles.
REQ-030 Back-to-back: two states with out_ready tied to 1 and in_valid held high -> the second state is accepted on the edge after DONE->IDLE, and both results are correct.
